// File: rtl/mult_prod_accum.sv
// Multiply-accumulate back end: sums groups of 8-bit products and hands each sum over a valid/ready port.
// Optional build macro MULT_ACCUM_SAT_EN turns the wrapping adder into a saturating one.
module mult_prod_accum #(
  parameter int ACC_LEN = 4,
  parameter int CNT_W   = 3,
  parameter int ACC_W   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [7:0]       product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_cnt
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ACC_LEN - 1);

  // Accumulator add of one unsigned product; saturates at all-ones when enabled.
  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                               input logic [7:0]       b);
`ifdef MULT_ACCUM_SAT_EN
    logic [ACC_W:0] s;
    s = {1'b0, a} + (ACC_W+1)'(b);
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
`else
    return a + ACC_W'(b);
`endif
  endfunction

  state_t           r_state;
  logic [ACC_W-1:0] r_acc_p0;
  logic [CNT_W-1:0] r_cnt_p0;
  logic [ACC_W-1:0] r_sum_p1;
  logic [CNT_W-1:0] r_cnt_p1;
  logic             r_vld_p1;

  logic             w_in_acc;
  logic             w_out_acc;
  logic             w_close;
  logic [ACC_W-1:0] w_sum;
  logic [CNT_W-1:0] w_cnt_inc;

  assign in_ready  = (r_state == ACCUM);
  assign w_in_acc  = in_valid & in_ready;
  assign w_out_acc = r_vld_p1 & out_ready;
  assign w_close   = w_in_acc & (in_last | (r_cnt_p0 == LAST_IDX));
  assign w_sum     = acc_add(r_acc_p0, product);
  assign w_cnt_inc = r_cnt_p0 + CNT_W'(1);

  // p0 -> p1: accumulate, and on the closing product move the sum into the output register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ACCUM;
      r_acc_p0 <= '0;
      r_cnt_p0 <= '0;
      r_sum_p1 <= '0;
      r_cnt_p1 <= '0;
      r_vld_p1 <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_close) begin
            r_sum_p1 <= w_sum;
            r_cnt_p1 <= w_cnt_inc;
            r_vld_p1 <= 1'b1;
            r_acc_p0 <= '0;
            r_cnt_p0 <= '0;
            r_state  <= HOLD;
          end else if (w_in_acc) begin
            r_acc_p0 <= w_sum;
            r_cnt_p0 <= w_cnt_inc;
          end
        end
        HOLD: begin
          // Result stays frozen until the consumer takes it.
          if (w_out_acc) begin
            r_vld_p1 <= 1'b0;
            r_state  <= ACCUM;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

  assign out_valid = r_vld_p1;
  assign out_sum   = r_sum_p1;
  assign out_cnt   = r_cnt_p1;

endmodule
